// File: rtl/sram_ctl.sv
// Single-port SRAM controller: clears every word at power-up, then serves byte-masked writes and reads.
// Latency: read data 1 cycle after the accepting edge (2 when SRAM_CTL_OUTREG_EN is defined); writes produce no response.
// Backpressure: req_ready is low only while clearing; one request per cycle afterwards, responses cannot be stalled.
module sram_ctl #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  init_done
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int BE_W  = DATA_W/8;

    typedef enum logic {
        S_INIT  = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   init_cnt;
    logic [ADDR_W-1:0]   init_cnt_nxt;
    logic                init_wr;
    logic                accept;
    logic                wr_acc;
    logic                rd_acc;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                rd_vld;
    logic [DATA_W-1:0]   rd_dat;

    assign accept = req_valid && req_ready;
    assign wr_acc = accept && req_we;
    assign rd_acc = accept && !req_we;

    // State and clear-address registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
        end
    end

    // Next state: sweep every address once with zeros, then serve requests until reset.
    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        req_ready    = 1'b0;
        init_done    = 1'b0;
        init_wr      = 1'b0;
        case (state)
            S_INIT: begin
                init_wr      = 1'b1;
                init_cnt_nxt = init_cnt + ADDR_W'(1);
                if (init_cnt == ADDR_W'(DEPTH-1)) begin
                    state_nxt = S_READY;
                end
            end
            S_READY: begin
                req_ready = 1'b1;
                init_done = 1'b1;
            end
        endcase
    end

    // Memory array: clear sweep has priority; accepted writes touch only enabled bytes.
    always_ff @(posedge clk) begin
        if (init_wr) begin
            mem[init_cnt] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < BE_W; i++) begin
                if (req_be[i]) begin
                    mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read stage: data only changes on an accepted read so it holds between responses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_vld <= 1'b0;
            rd_dat <= '0;
        end else begin
            rd_vld <= rd_acc;
            if (rd_acc) begin
                rd_dat <= mem[req_addr];
            end
        end
    end

`ifdef SRAM_CTL_OUTREG_EN
    logic                o_vld;
    logic [DATA_W-1:0]   o_dat;

    // Extra output stage: valid and data move together, data held when no response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_vld <= 1'b0;
            o_dat <= '0;
        end else begin
            o_vld <= rd_vld;
            if (rd_vld) begin
                o_dat <= rd_dat;
            end
        end
    end

    assign resp_valid = o_vld;
    assign resp_rdata = o_dat;
`else
    assign resp_valid = rd_vld;
    assign resp_rdata = rd_dat;
`endif

endmodule

// File: doc/sram_ctl.md
SRAM_CTL -- requirements
Module: sram_ctl

Interface
REQ-001 SHALL have parameter DATA_W, default 64, data word width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; depth DEPTH = 2**ADDR_W words.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  controller accepts a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  ADDR_W  word address.
REQ-009 SHALL have port req_wdata  input  DATA_W  write data.
REQ-010 SHALL have port req_be  input  DATA_W/8  byte enables; bit i covers data bits [8i+7:8i].
REQ-011 SHALL have port resp_valid  output  1  read data valid, one-cycle pulse per read.
REQ-012 SHALL have port resp_rdata  output  DATA_W  read data.
REQ-013 SHALL have port init_done  output  1  memory clear complete.

Function
REQ-014 SHALL implement a two-state FSM: INIT and READY.
REQ-015 In INIT, SHALL write zero to address init_cnt each cycle and increment init_cnt; after the write to DEPTH-1, SHALL move to READY.
REQ-016 INIT SHALL last exactly DEPTH cycles; the first rising edge after rst deasserts clears address 0.
REQ-017 req_ready and init_done SHALL be 0 in INIT and 1 in READY; READY SHALL have no exit except reset.
REQ-018 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1; req_* SHALL be ignored otherwise, including X values.
REQ-019 An accepted write SHALL update only the bytes whose req_be bit is 1; other bytes SHALL be unchanged. It SHALL produce no response.
REQ-020 A write with req_be all zero SHALL be accepted and SHALL leave memory unchanged.
REQ-021 An accepted read SHALL assert resp_valid for exactly one cycle, with resp_rdata equal to the word at req_addr. Latency is 1 cycle after the accepting edge (see REQ-027).
REQ-022 One request per cycle SHALL be sustained: back-to-back reads SHALL give back-to-back responses in request order. There is no response backpressure.
REQ-023 A read accepted the cycle after a write to the same address SHALL return the newly written data.
REQ-024 resp_rdata SHALL hold its last value while resp_valid is 0.

Reset
REQ-025 While rst = 0, regardless of clk: state = INIT, init_cnt = 0, req_ready = 0, init_done = 0, resp_valid = 0, resp_rdata = 0, and the read pipeline is cleared.
REQ-026 Reset asserted mid-operation SHALL discard in-flight reads (no resp_valid). Memory SHALL read all-zero after the subsequent INIT completes.

Configuration
REQ-027 Macro SRAM_CTL_OUTREG_EN: when defined, an extra output register SHALL be inserted, giving read latency 2 cycles with resp_valid and resp_rdata delayed together. When undefined, read latency SHALL be 1 cycle. Throughput and all other behaviour are identical in both cases.

Verification (DATA_W=64, ADDR_W=5; latency L = 1, or 2 with SRAM_CTL_OUTREG_EN)
REQ-028 Release rst -> req_ready is 0 for exactly 32 cycles, then 1 with init_done 1; read addr 31 -> resp_rdata 0 after L cycles.
REQ-029 Write addr 3 with 0x1122334455667788, be 0xFF, then read addr 3 the next cycle -> resp_valid pulses once L cycles after acceptance with 0x1122334455667788.
REQ-030 Write addr 4 with 0x0123456789ABCDEF, be 0xFF; then write 0xFFFFFFFFFFFFFFFF, be 0x0F; then read addr 4 -> 0x01234567FFFFFFFF. Further write with be 0x00 -> read still returns 0x01234567FFFFFFFF.
REQ-031 Write addr i = 0..31 with data {32'h0, i}; then issue reads 0..31 on consecutive cycles -> resp_valid high for 32 consecutive cycles, data 0..31 in order.
REQ-032 Assert rst for 1 cycle while reads are in flight -> all outputs 0 immediately, no stale resp_valid; after re-INIT, reads of addr 3 and addr 4 return 0.
